cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//  Sequencing controller for the direct-mapped data cache in the MEM stage. Serves CPU loads/stores
//  against the cache array, stalls the pipeline on misses and stores, refills lines from data memory
//  over a req/ack handshake, and clears all valid bits after reset. Policy: write-through, no-write-allocate.
// PARAMETERS
//  DATA_W  32  data/address width
//  SET_W   3   set index bits; 2**SET_W lines, index = addr[SET_W+1:2]
//  TAG_W   27  tag bits = addr[31:SET_W+2]; must equal DATA_W-SET_W-2
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  cpu_req      in   1       MEM-stage access valid
//  cpu_we       in   1       1 = store, 0 = load
//  cpu_byte     in   1       1 = byte access (addr[1:0] selects lane), 0 = word
//  cpu_addr     in   DATA_W  byte address
//  cpu_wdata    in   DATA_W  store data (byte in [7:0] when cpu_byte)
//  cpu_rdata    out  DATA_W  load data; byte loads zero-extended
//  stall        out  1       freeze pipeline while 1
//  arr_set      out  SET_W   set index to cache array
//  arr_tag      out  TAG_W   tag to compare/write
//  arr_hit      in   1       array: valid && tag match at arr_set
//  arr_rdata    in   DATA_W  array word at arr_set
//  arr_wr       out  1       write arr_wdata/arr_tag to arr_set, set valid
//  arr_wdata    out  DATA_W  word written to array
//  arr_inval    out  1       clear valid at arr_set
//  mem_req      out  1       memory request, held until mem_ack
//  mem_we       out  1       1 = word write, 0 = word read
//  mem_addr     out  DATA_W  word-aligned address (addr[1:0]=0)
//  mem_wdata    out  DATA_W  merged store word
//  mem_wstrb    out  4       byte enables for writes
//  mem_ack      in   1       one-cycle pulse: read data valid / write done
//  mem_rdata    in   DATA_W  read data, valid with mem_ack
//  hit_cnt      out  32      load hits (see CONFIGURATION)
//  miss_cnt     out  32      load misses (see CONFIGURATION)
// BEHAVIOUR
//  - States: INIT, IDLE, RD_MISS, REFILL, WR_THRU. Reset -> INIT, set counter 0; outputs reset to 0
//    except stall=1. arr_set/arr_tag always driven from cpu_addr except in INIT (arr_set=counter).
//  - INIT: arr_inval=1, stall=1, counter++ each cycle; after set 2**SET_W-1 -> IDLE (2**SET_W cycles).
//  - IDLE, no cpu_req: stall=0, no array/memory activity.
//  - IDLE load hit: cpu_rdata=arr_rdata (lane-selected) combinationally, stall=0, zero added cycles.
//  - IDLE load miss: stall=1 -> RD_MISS. RD_MISS: mem_req=1, mem_we=0 until mem_ack; on ack capture
//    mem_rdata -> REFILL. REFILL: arr_wr=1 with captured word -> IDLE; the now-hitting load releases
//    stall. Miss penalty = ack latency + 2 cycles. Ack in the first RD_MISS cycle is legal.
//  - IDLE store: stall=1 -> WR_THRU. On hit, arr_wr=1 in the IDLE cycle with byte-merged word;
//    miss leaves array untouched. WR_THRU: mem_req=1, mem_we=1, mem_wstrb=1111 (word) or one-hot
//    lane (byte) until mem_ack -> IDLE; stall drops cycle after ack. Store-hit arr_wr fires once only.
//  - mem_addr/mem_wdata/mem_wstrb registered on leaving IDLE; stable while mem_req=1.
//  - cpu_req or cpu_addr changing mid-miss is ignored; transaction completes with latched values.
//  - mem_ack outside RD_MISS/WR_THRU ignored. Reset mid-transaction: mem_req drops asynchronously,
//    fill data discarded, INIT re-runs.
// CONFIGURATION
//  CACHE_STATS_EN defined: hit_cnt/miss_cnt count loads at IDLE lookup (each miss counted once, not
//  its retry hit); saturate at 2**32-1; reset to 0. Undefined: both tied to 0, no counter flops.
// TESTING
//  1 reset, hold 10 cycles -> stall=1 and arr_inval for sets 0..7 in 8 consecutive cycles, then stall=0.
//  2 load 0x40, ack after 3 cycles, mem_rdata=0xDEADBEEF -> stall 5 cycles, cpu_rdata=0xDEADBEEF; repeat -> stall 0.
//  3 byte store 0xAB to 0x41 (line resident) -> arr_wdata=0xDEADABEF, mem_wstrb=0010, stall until ack+1.
//  4 store to 0x80 (miss) -> arr_wr never asserted, one mem write; later load 0x80 misses.
//  5 rst pulsed while RD_MISS awaits ack -> mem_req=0 immediately, INIT re-runs, late ack ignored.
//  6 CACHE_STATS_EN: tests 2 then 4 loads of 0x40 -> hit_cnt=5, miss_cnt=1; undefined -> both 0.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl -- sequencing controller for the direct-mapped, write-through,
// no-write-allocate data cache in the MEM stage.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cpu_req/we/byte          MEM-stage access valid, store, byte access
//   cpu_addr, cpu_wdata      byte address, store data (byte in [7:0])
//   cpu_rdata                load data, byte loads zero-extended
//   stall                    freeze pipeline while 1
//   arr_set/arr_tag          lookup/write index and tag to the cache array
//   arr_hit/arr_rdata        array lookup result
//   arr_wr/arr_wdata         write word+tag to arr_set and set valid
//   arr_inval                clear valid at arr_set
//   mem_req/we/addr/wdata/wstrb, mem_ack/rdata   word memory handshake
//   hit_cnt/miss_cnt         load hit/miss statistics
//
// Build option
//   CACHE_STATS_EN  when defined, hit_cnt/miss_cnt are saturating counters of
//                   loads at IDLE lookup; otherwise both are tied to zero.

module cache_ctrl #(
  parameter int DATA_W = 32,
  parameter int SET_W  = 3,
  parameter int TAG_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [SET_W-1:0]  arr_set,
  output logic [TAG_W-1:0]  arr_tag,
  input  logic              arr_hit,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              arr_wr,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              arr_inval,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF = SET_W + 2;

  typedef enum logic [2:0] {INIT, IDLE, RD_MISS, REFILL, WR_THRU} state_t;

  state_t              state;
  logic [SET_W-1:0]    cnt;
  logic [DATA_W-1:2]   lat_addr;   // word address latched when leaving IDLE
  logic [DATA_W-1:0]   fill;
  // Set on return to IDLE after a completed miss/store: the pipeline is still
  // presenting that same access for one cycle and must not re-issue it.
  logic                done;

  logic [1:0]          lane;
  logic [DATA_W-1:2]   src;
  logic [DATA_W-1:0]   merged;
  logic [7:0]          rbyte;
  logic [3:0]          strb;
  logic                acc, go;

  assign lane = cpu_addr[1:0];
  assign acc  = (state == IDLE) && cpu_req && !done;
  assign go   = acc && (cpu_we || !arr_hit);   // needs a memory transaction

  // Refill and write-through must use the latched address so that the
  // pipeline changing cpu_addr mid-transaction cannot corrupt the array.
  assign src     = (state == IDLE) ? cpu_addr[DATA_W-1:2] : lat_addr;
  assign arr_set = (state == INIT) ? cnt : src[OFF-1:2];
  assign arr_tag = src[DATA_W-1:OFF];

  assign arr_inval = (state == INIT) && !rst;
  assign rbyte     = arr_rdata[{lane, 3'b000} +: 8];
  assign strb      = cpu_byte ? (4'b0001 << lane) : 4'b1111;

  always_comb begin
    merged = arr_hit ? arr_rdata : '0;
    if (cpu_byte) merged[{lane, 3'b000} +: 8] = cpu_wdata[7:0];
    else          merged = cpu_wdata;
  end

  always_comb begin
    cpu_rdata = '0;
    if (state == IDLE)
      cpu_rdata = cpu_byte ? {{(DATA_W-8){1'b0}}, rbyte} : arr_rdata;
  end

  always_comb begin
    stall = 1'b1;
    if (state == IDLE) stall = go;
  end

  assign arr_wr    = (state == REFILL) || (acc && cpu_we && arr_hit);
  assign arr_wdata = (state == REFILL) ? fill : merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      lat_addr  <= '0;
      fill      <= '0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            lat_addr  <= cpu_addr[DATA_W-1:2];
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[DATA_W-1:2], 2'b00};
            mem_wdata <= cpu_we ? merged : '0;
            mem_wstrb <= cpu_we ? strb : 4'b0000;
            state     <= cpu_we ? WR_THRU : RD_MISS;
          end
        end
        RD_MISS: if (mem_ack) begin
          fill    <= mem_rdata;
          mem_req <= 1'b0;
          state   <= REFILL;
        end
        REFILL: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        WR_THRU: if (mem_ack) begin
          mem_req <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Only fresh IDLE lookups count; the replay hit after a refill has done=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (acc && !cpu_we) begin
      if (arr_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
